// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETURN = 2'd3
    } arb_state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, the side that did not win last time wins.
module rr_pick2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last,
    output logic o_grant,
    output logic o_any
);

    always_comb begin
        o_any   = i_valid0 | i_valid1;
        o_grant = 1'b0;
        if (i_valid0 && i_valid1) begin
            o_grant = ~i_last;
        end else if (i_valid1) begin
            o_grant = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters, one transaction at a time.
// Optional issue timeout enabled with `define ALU_ARB_TIMEOUT_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_req0_a,
    input  logic [DATA_WIDTH-1:0] i_req0_b,
    input  logic [1:0]            i_req0_op,
    input  logic                  i_req0_signed,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    output logic [DATA_WIDTH-1:0] o_req0_result,
    output logic                  o_req0_error,
    output logic                  o_req0_result_valid,
    input  logic                  i_req0_result_ready,
    input  logic [DATA_WIDTH-1:0] i_req1_a,
    input  logic [DATA_WIDTH-1:0] i_req1_b,
    input  logic [1:0]            i_req1_op,
    input  logic                  i_req1_signed,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    output logic [DATA_WIDTH-1:0] o_req1_result,
    output logic                  o_req1_error,
    output logic                  o_req1_result_valid,
    input  logic                  i_req1_result_ready,
    output logic [DATA_WIDTH-1:0] o_alu_input_a,
    output logic [DATA_WIDTH-1:0] o_alu_input_b,
    output logic [1:0]            o_alu_input_op,
    output logic                  o_alu_input_signed,
    output logic                  o_alu_input_valid,
    input  logic                  i_alu_input_ready,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_alu_error,
    input  logic                  i_alu_valid,
    output logic                  o_alu_result_ready,
    output logic                  o_busy,
    output logic                  o_grant
);

    arb_state_e            state_q, state_d;
    logic                  grant_q, grant_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [1:0]            op_q, op_d;
    logic                  signed_q, signed_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  error_q, error_d;
    logic                  pick;
    logic                  pick_any;
    logic                  owner_ready;
    logic                  timeout_hit;

    rr_pick2 u_pick (
        .i_valid0 (i_req0_valid),
        .i_valid1 (i_req1_valid),
        .i_last   (grant_q),
        .o_grant  (pick),
        .o_any    (pick_any)
    );

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == S_ISSUE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (cnt_q == CNT_LAST);
`else
    // Without the timeout the ISSUE state simply waits for the ALU.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    assign owner_ready = grant_q ? i_req1_result_ready : i_req0_result_ready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        signed_d     = signed_q;
        result_d     = result_q;
        error_d      = error_q;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_any && !rst) begin
                    o_req0_ready = ~pick;
                    o_req1_ready = pick;
                    grant_d      = pick;
                    a_d          = pick ? i_req1_a : i_req0_a;
                    b_d          = pick ? i_req1_b : i_req0_b;
                    op_d         = pick ? i_req1_op : i_req0_op;
                    signed_d     = pick ? i_req1_signed : i_req0_signed;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_alu_input_ready) begin
                    state_d = S_WAIT;
                end else if (timeout_hit) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    state_d  = S_RETURN;
                end
            end
            S_WAIT: begin
                if (i_alu_valid) begin
                    result_d = i_alu_result;
                    error_d  = i_alu_error;
                    state_d  = S_RETURN;
                end
            end
            S_RETURN: begin
                if (owner_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            grant_q  <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            signed_q <= 1'b0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            signed_q <= signed_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign o_alu_input_a      = a_q;
    assign o_alu_input_b      = b_q;
    assign o_alu_input_op     = op_q;
    assign o_alu_input_signed = signed_q;
    assign o_alu_input_valid  = (state_q == S_ISSUE);
    assign o_alu_result_ready = (state_q == S_WAIT);
    assign o_busy             = (state_q != S_IDLE);
    assign o_grant            = grant_q;

    // Result data is only ever shown on the owner's channel.
    assign o_req0_result_valid = (state_q == S_RETURN) && !grant_q;
    assign o_req1_result_valid = (state_q == S_RETURN) && grant_q;
    assign o_req0_result       = grant_q ? '0 : result_q;
    assign o_req1_result       = grant_q ? result_q : '0;
    assign o_req0_error        = !grant_q && error_q;
    assign o_req1_error        = grant_q && error_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a behavioural ALU and arbiter model.
// Define ALU_ARB_TIMEOUT_EN to also exercise the issue timeout.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic [1:0]    i_req0_op, i_req1_op;
    logic          i_req0_signed, i_req1_signed;
    logic          i_req0_valid, i_req1_valid;
    logic          o_req0_ready, o_req1_ready;
    logic [DW-1:0] o_req0_result, o_req1_result;
    logic          o_req0_error, o_req1_error;
    logic          o_req0_result_valid, o_req1_result_valid;
    logic          i_req0_result_ready, i_req1_result_ready;
    logic [DW-1:0] o_alu_input_a, o_alu_input_b;
    logic [1:0]    o_alu_input_op;
    logic          o_alu_input_signed, o_alu_input_valid;
    logic          i_alu_input_ready;
    logic [DW-1:0] i_alu_result;
    logic          i_alu_error, i_alu_valid;
    logic          o_alu_result_ready;
    logic          o_busy, o_grant;

    int n_tests = 0;
    int n_fail  = 0;
    int last_grant;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_op(i_req0_op),
        .i_req0_signed(i_req0_signed), .i_req0_valid(i_req0_valid),
        .o_req0_ready(o_req0_ready), .o_req0_result(o_req0_result),
        .o_req0_error(o_req0_error), .o_req0_result_valid(o_req0_result_valid),
        .i_req0_result_ready(i_req0_result_ready),
        .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_op(i_req1_op),
        .i_req1_signed(i_req1_signed), .i_req1_valid(i_req1_valid),
        .o_req1_ready(o_req1_ready), .o_req1_result(o_req1_result),
        .o_req1_error(o_req1_error), .o_req1_result_valid(o_req1_result_valid),
        .i_req1_result_ready(i_req1_result_ready),
        .o_alu_input_a(o_alu_input_a), .o_alu_input_b(o_alu_input_b),
        .o_alu_input_op(o_alu_input_op), .o_alu_input_signed(o_alu_input_signed),
        .o_alu_input_valid(o_alu_input_valid), .i_alu_input_ready(i_alu_input_ready),
        .i_alu_result(i_alu_result), .i_alu_error(i_alu_error),
        .i_alu_valid(i_alu_valid), .o_alu_result_ready(o_alu_result_ready),
        .o_busy(o_busy), .o_grant(o_grant)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ALU: {error, result}
    function automatic logic [16:0] ref_alu(input logic [1:0] op, input logic sg,
                                            input logic [15:0] a, input logic [15:0] b);
        int sa, sb, r;
        logic e;
        sa = sg ? int'($signed(a)) : int'(a);
        sb = sg ? int'($signed(b)) : int'(b);
        e  = 1'b0;
        case (op)
            OP_ADD: r = sa + sb;
            OP_SUB: r = sa - sb;
            OP_MUL: r = sa * sb;
            default: begin
                if (sb == 0) begin
                    e = 1'b1;
                    r = -1;
                end else begin
                    r = sa / sb;
                end
            end
        endcase
        return {e, r[15:0]};
    endfunction

    task automatic idle_inputs();
        i_req0_valid        = 1'b0;
        i_req1_valid        = 1'b0;
        i_req0_result_ready = 1'b0;
        i_req1_result_ready = 1'b0;
        i_alu_input_ready   = 1'b0;
        i_alu_valid         = 1'b0;
        i_alu_error         = 1'b0;
        i_alu_result        = '0;
    endtask

    task automatic check_result(input int w, input logic [16:0] exp, input string tag);
        check({tag, "_rv0"}, o_req0_result_valid, w == 0);
        check({tag, "_rv1"}, o_req1_result_valid, w == 1);
        check({tag, "_res"}, (w == 1) ? o_req1_result : o_req0_result, exp[15:0]);
        check({tag, "_err"}, (w == 1) ? o_req1_error : o_req0_error, exp[16]);
    endtask

    task automatic run_txn(input bit v0, input bit v1,
                           input logic [15:0] a0, input logic [15:0] b0,
                           input logic [1:0] op0, input bit s0,
                           input logic [15:0] a1, input logic [15:0] b1,
                           input logic [1:0] op1, input bit s1,
                           input int acc_d, input int lat, input int cons);
        int w;
        logic [16:0] exp, stub;
        w = (v0 && v1) ? 1 - last_grant : (v1 ? 1 : 0);
        exp = (w == 1) ? ref_alu(op1, s1, a1, b1) : ref_alu(op0, s0, a0, b0);
        @(posedge clk); #1;
        i_req0_a = a0; i_req0_b = b0; i_req0_op = op0; i_req0_signed = s0;
        i_req1_a = a1; i_req1_b = b1; i_req1_op = op1; i_req1_signed = s1;
        i_req0_valid = v0;
        i_req1_valid = v1;
        @(negedge clk);
        check("accept_rdy0", o_req0_ready, w == 0);
        check("accept_rdy1", o_req1_ready, w == 1);
        @(posedge clk); #1;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        last_grant = w;
        for (int i = 0; i <= acc_d; i++) begin
            @(negedge clk);
            check("issue_valid", o_alu_input_valid, 1);
            check("issue_a", o_alu_input_a, (w == 1) ? a1 : a0);
            check("issue_b", o_alu_input_b, (w == 1) ? b1 : b0);
            check("issue_op", o_alu_input_op, (w == 1) ? op1 : op0);
            check("issue_sg", o_alu_input_signed, (w == 1) ? s1 : s0);
            check("issue_grant", o_grant, w);
            if (i < acc_d) begin
                @(posedge clk); #1;
            end
        end
        stub = ref_alu(o_alu_input_op, o_alu_input_signed, o_alu_input_a, o_alu_input_b);
        i_alu_input_ready = 1'b1;
        @(posedge clk); #1;
        i_alu_input_ready = 1'b0;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("wait_rr", o_alu_result_ready, 1);
            check("wait_iv", o_alu_input_valid, 0);
            @(posedge clk); #1;
        end
        i_alu_valid  = 1'b1;
        i_alu_result = stub[15:0];
        i_alu_error  = stub[16];
        @(negedge clk);
        check("wait_rr_last", o_alu_result_ready, 1);
        @(posedge clk); #1;
        i_alu_valid  = 1'b0;
        i_alu_result = DW'($urandom);
        i_alu_error  = 1'($urandom);
        for (int i = 0; i < cons; i++) begin
            i_req0_valid = 1'($urandom);
            i_req1_valid = 1'($urandom);
            if (w == 1) i_req0_result_ready = 1'($urandom);
            else        i_req1_result_ready = 1'($urandom);
            @(negedge clk);
            check_result(w, exp, "ret_hold");
            check("ret_rdy0", o_req0_ready, 0);
            check("ret_rdy1", o_req1_ready, 0);
            check("ret_iv", o_alu_input_valid, 0);
            @(posedge clk); #1;
        end
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        i_req0_result_ready = (w == 0);
        i_req1_result_ready = (w == 1);
        @(negedge clk);
        check_result(w, exp, "ret");
        @(posedge clk); #1;
        i_req0_result_ready = 1'b0;
        i_req1_result_ready = 1'b0;
        @(negedge clk);
        check("done_busy", o_busy, 0);
        check("done_rv0", o_req0_result_valid, 0);
        check("done_rv1", o_req1_result_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        i_req0_a = '0; i_req0_b = '0; i_req0_op = '0; i_req0_signed = 1'b0;
        i_req1_a = '0; i_req1_b = '0; i_req1_op = '0; i_req1_signed = 1'b0;
        idle_inputs();
        last_grant = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_grant", o_grant, 1);
        check("rst_busy", o_busy, 0);
        check("rst_iv", o_alu_input_valid, 0);
        check("rst_rr", o_alu_result_ready, 0);
        check("rst_rv0", o_req0_result_valid, 0);
        check("rst_rv1", o_req1_result_valid, 0);
        check("rst_res0", o_req0_result, 0);
        check("rst_alu_a", o_alu_input_a, 0);

        // Both valid from reset: req0, then req1, then req0 again
        run_txn(1, 1, 16'd10, 16'd4, OP_SUB, 0, 16'd6, 16'd7, OP_MUL, 0, 0, 0, 0);
        check("rr_first", last_grant, 0);
        run_txn(1, 1, 16'd10, 16'd4, OP_SUB, 0, 16'd6, 16'd7, OP_MUL, 0, 1, 1, 0);
        check("rr_second", o_grant, 1);
        run_txn(1, 1, 16'd1, 16'd2, OP_ADD, 0, 16'd3, 16'd4, OP_ADD, 0, 0, 0, 0);
        check("rr_third", o_grant, 0);

        // Single requester add, ALU answers two cycles later
        run_txn(1, 0, 16'd5, 16'd3, OP_ADD, 0, 16'd0, 16'd0, OP_ADD, 0, 0, 2, 0);
        check("add_grant", o_grant, 0);

        // Slow consumer
        run_txn(1, 0, 16'hfff0, 16'd20, OP_ADD, 1, 16'd9, 16'd9, OP_SUB, 0, 2, 1, 10);

        // Divide by zero error
        run_txn(0, 1, 16'd0, 16'd0, OP_ADD, 0, 16'd7, 16'd0, OP_DIV, 0, 0, 1, 1);
        run_txn(1, 0, 16'hfff9, 16'd2, OP_DIV, 1, 16'd0, 16'd0, OP_ADD, 0, 1, 0, 0);

        // Reset while waiting on the ALU
        @(posedge clk); #1;
        i_req0_a = 16'd1; i_req0_b = 16'd2; i_req0_op = OP_ADD;
        i_req0_valid = 1'b1;
        @(posedge clk); #1;
        i_req0_valid = 1'b0;
        i_alu_input_ready = 1'b1;
        @(posedge clk); #1;
        i_alu_input_ready = 1'b0;
        @(negedge clk);
        check("rstw_wait_rr", o_alu_result_ready, 1);
        check("rstw_grant0", o_grant, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_grant = 1;
        @(negedge clk);
        check("rstw_busy", o_busy, 0);
        check("rstw_grant", o_grant, 1);
        check("rstw_rr", o_alu_result_ready, 0);
        check("rstw_rv0", o_req0_result_valid, 0);
        i_alu_valid = 1'b1;
        i_alu_result = 16'h1234;
        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rstw_ign_busy", o_busy, 0);
            check("rstw_ign_rv0", o_req0_result_valid, 0);
            check("rstw_ign_rv1", o_req1_result_valid, 0);
        end
        i_alu_valid = 1'b0;

`ifdef ALU_ARB_TIMEOUT_EN
        @(posedge clk); #1;
        i_req1_a = 16'd3; i_req1_b = 16'd4; i_req1_op = OP_MUL;
        i_req1_valid = 1'b1;
        @(posedge clk); #1;
        i_req1_valid = 1'b0;
        last_grant = 1;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("to_issue", o_alu_input_valid, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("to_iv_drop", o_alu_input_valid, 0);
        check_result(1, 17'h10000, "to");
        i_req1_result_ready = 1'b1;
        @(posedge clk); #1;
        i_req1_result_ready = 1'b0;
        @(negedge clk);
        check("to_done", o_busy, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            bit v0, v1;
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            run_txn(v0, v1,
                    DW'($urandom), DW'($urandom_range(0, 40)), 2'($urandom), 1'($urandom),
                    DW'($urandom), DW'($urandom_range(0, 40)), 2'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
